// File: rtl/i2c_master_byte_if.sv
// Controller byte handshake and open-drain pad controls for i2c_master_byte.
// master = controller side, slave = byte engine side.
interface i2c_master_byte_if;
    logic       isReady;
    logic       start;
    logic       send;
    logic [7:0] datasend;
    logic       sended;
    logic       receive;
    logic [7:0] datareceive;
    logic       received;
    logic       ack_error;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        output start,
        output send,
        output datasend,
        output receive,
        output sda_i,
        input  isReady,
        input  sended,
        input  datareceive,
        input  received,
        input  ack_error,
        input  scl_oe,
        input  sda_oe
    );

    modport slave (
        input  start,
        input  send,
        input  datasend,
        input  receive,
        input  sda_i,
        output isReady,
        output sended,
        output datareceive,
        output received,
        output ack_error,
        output scl_oe,
        output sda_oe
    );
endinterface

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: turns controller byte requests into open-drain
// SCL/SDA phases, four quarter-period ticks per bit.
module i2c_master_byte #(
    parameter int CLK_DIV = 125
) (
    input  logic             clk,
    input  logic             reset,
    i2c_master_byte_if.slave bus
);
    localparam int            DW      = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RESTART,
        S_TX,
        S_TXACK,
        S_RX,
        S_RXACK,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_div;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic [7:0]    r_dout;
    logic          r_ready;
    logic          r_sended;
    logic          r_snd_pend;
    logic          r_received;
    logic          r_ackerr;
    logic          r_nack;
    logic          r_scl;
    logic          r_sda;

    logic          w_tick;
    logic          w_dec;
    logic [7:0]    w_rx_shift;

    assign w_tick     = (r_div == DIV_MAX);
    assign w_rx_shift = {r_rx[6:0], bus.sda_i};
    // End of an ACK bit that did not end in a slave NACK
    assign w_dec = w_tick && (r_q == 2'd3) &&
                   ((r_state == S_RXACK) ||
                    ((r_state == S_TXACK) && !r_nack));

    assign bus.isReady     = r_ready;
    assign bus.sended      = r_sended;
    assign bus.datareceive = r_dout;
    assign bus.received    = r_received;
    assign bus.ack_error   = r_ackerr;
    assign bus.scl_oe      = r_scl;
    assign bus.sda_oe      = r_sda;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_q        <= 2'd0;
            r_bit      <= 3'd0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_dout     <= 8'h00;
            r_ready    <= 1'b1;
            r_sended   <= 1'b0;
            r_snd_pend <= 1'b0;
            r_received <= 1'b0;
            r_ackerr   <= 1'b0;
            r_nack     <= 1'b0;
            r_scl      <= 1'b0;
            r_sda      <= 1'b0;
        end else begin
            // sended rises the clock after a latch, leaving a one-clock
            // low gap between back-to-back TX bytes
            r_snd_pend <= 1'b0;
            if (r_snd_pend)
                r_sended <= 1'b1;

            if (r_state == S_IDLE) begin
                r_div <= '0;
                if (bus.send && bus.start) begin
                    r_tx       <= bus.datasend;
                    r_snd_pend <= 1'b1;
                    r_ackerr   <= 1'b0;
                    r_nack     <= 1'b0;
                    r_ready    <= 1'b0;
                    r_q        <= 2'd0;
                    r_sda      <= 1'b1;
                    r_scl      <= 1'b0;
                    r_state    <= S_START;
                end
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    unique case (r_state)
                        S_START: begin
                            if (r_q == 2'd0) begin
                                r_scl <= 1'b1;
                            end else begin
                                r_state <= S_TX;
                                r_q     <= 2'd0;
                                r_bit   <= 3'd7;
                                r_scl   <= 1'b1;
                                r_sda   <= ~r_tx[7];
                            end
                        end
                        S_RESTART: begin
                            unique case (r_q)
                                2'd0: r_scl <= 1'b0;
                                2'd1: r_sda <= 1'b1;
                                2'd2: r_scl <= 1'b1;
                                default: begin
                                    r_state <= S_TX;
                                    r_bit   <= 3'd7;
                                    r_sda   <= ~r_tx[7];
                                end
                            endcase
                        end
                        S_TX: begin
                            unique case (r_q)
                                2'd1: r_scl <= 1'b0;
                                2'd3: begin
                                    r_scl <= 1'b1;
                                    if (r_bit == 3'd0) begin
                                        r_state <= S_TXACK;
                                        r_sda   <= 1'b0;
                                    end else begin
                                        r_bit <= r_bit - 3'd1;
                                        r_sda <= ~r_tx[r_bit - 3'd1];
                                    end
                                end
                                default: ;
                            endcase
                        end
                        S_TXACK: begin
                            unique case (r_q)
                                2'd1: begin
                                    r_scl <= 1'b0;
                                    if (bus.sda_i) begin
                                        r_nack   <= 1'b1;
                                        r_ackerr <= 1'b1;
                                    end
                                end
                                2'd3: begin
                                    r_sended <= 1'b0;
                                    if (r_nack) begin
                                        r_state <= S_STOP;
                                        r_sda   <= 1'b1;
                                        r_scl   <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        S_RX: begin
                            unique case (r_q)
                                2'd1: begin
                                    r_scl <= 1'b0;
                                    r_rx  <= w_rx_shift;
                                    if (r_bit == 3'd0) begin
                                        r_dout     <= w_rx_shift;
                                        r_received <= 1'b1;
                                    end
                                end
                                2'd3: begin
                                    r_scl <= 1'b1;
                                    if (r_bit == 3'd0) begin
                                        r_state <= S_RXACK;
                                        r_sda   <= bus.receive;
                                    end else begin
                                        r_bit <= r_bit - 3'd1;
                                        r_sda <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        S_RXACK: begin
                            unique case (r_q)
                                2'd1: r_scl <= 1'b0;
                                2'd3: r_received <= 1'b0;
                                default: ;
                            endcase
                        end
                        S_STOP: begin
                            unique case (r_q)
                                2'd0: r_scl <= 1'b0;
                                2'd2: r_sda <= 1'b0;
                                2'd3: begin
                                    r_state <= S_IDLE;
                                    r_ready <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        default: r_state <= S_IDLE;
                    endcase

                    // Decision point overrides the per-state defaults above
                    if (w_dec) begin
                        r_q <= 2'd0;
                        if (bus.send) begin
                            r_tx       <= bus.datasend;
                            r_snd_pend <= 1'b1;
                            r_scl      <= 1'b1;
                            if (bus.start) begin
                                r_state <= S_RESTART;
                                r_sda   <= 1'b0;
                            end else begin
                                r_state <= S_TX;
                                r_bit   <= 3'd7;
                                r_sda   <= ~bus.datasend[7];
                            end
                        end else if (bus.receive) begin
                            r_state <= S_RX;
                            r_bit   <= 3'd7;
                            r_sda   <= 1'b0;
                            r_scl   <= 1'b1;
                        end else begin
                            r_state <= S_STOP;
                            r_sda   <= 1'b1;
                            r_scl   <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_byte.sv
// Scoreboard bench for i2c_master_byte with a clock-sampled I2C slave model.
// Stimulus queues expected bus/handshake events; the monitor pops them.
module tb_i2c_master_byte;
    localparam int DIV = 4;

    localparam int K_STA = 0;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    localparam int K_ACK = 3;
    localparam int K_STP = 4;
    localparam int K_END = 5;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic clk;
    logic reset;
    logic slave_pull;
    bit   nack_wr;
    bit   sb_off;
    int   n_cmp;
    int   n_bad;
    int   last_low;
    int   last_snd;
    exp_t sbq[$];
    logic [7:0] rdq[$];

    i2c_master_byte_if bus();

    i2c_master_byte #(.CLK_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.sda_i = ~(bus.sda_oe | slave_pull);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic string kname(input int k);
        case (k)
            K_STA:   return "start";
            K_WR:    return "wrbyte";
            K_RD:    return "rdbyte";
            K_ACK:   return "mack";
            K_STP:   return "stop";
            default: return "end";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input int kind, input int val);
        exp_t e;
        if (sb_off) return;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL sb_%s: got %0h, nothing expected", kname(kind), val);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_bad++;
                $display("FAIL sb_%s: got %s=%0h, required %s=%0h",
                         kname(kind), kname(kind), val, kname(e.kind), e.val);
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.sended;
            1:       return bus.received;
            default: return bus.isReady;
        endcase
    endfunction

    task automatic wait_lvl(input int sel, input logic lvl, input string nm);
        int n;
        n = 0;
        while (sig(sel) !== lvl && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) !== lvl) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_%s: still not %0b after %0d clocks", nm, lvl, n);
        end
    endtask

    task automatic wait_ready();
        wait_lvl(2, 1'b0, "ready_fall");
        wait_lvl(2, 1'b1, "ready_rise");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sended();
        wait_lvl(0, 1'b0, "sended_low");
        wait_lvl(0, 1'b1, "sended_rise");
    endtask

    // Slave model and output monitor, sampled on the falling clock edge
    initial begin
        logic scl_p, sda_p, scl_n, sda_n;
        logic rdy_p, rcv_p, snd_p;
        logic [7:0] sh, rcur;
        logic mack;
        bit act, rdm, first, rd_pend;
        int bitn, low_cnt, snd_cnt;
        scl_p = 1; sda_p = 1; rdy_p = 1; rcv_p = 0; snd_p = 0;
        sh = 0; rcur = 8'hFF; mack = 1;
        act = 0; rdm = 0; first = 0; rd_pend = 0;
        bitn = 0; low_cnt = 0; snd_cnt = 0;
        slave_pull = 1'b0;
        forever begin
            @(negedge clk);
            scl_n = ~bus.scl_oe;
            sda_n = bus.sda_i;
            if (!reset) begin
                act = 0; rdm = 0; rd_pend = 0; bitn = 0;
                slave_pull = 1'b0;
            end else if (scl_p && scl_n && sda_p && !sda_n) begin
                sb_check(K_STA, act ? 1 : 0);
                act = 1; first = 1; rdm = 0; rd_pend = 0; bitn = 0;
                slave_pull = 1'b0;
            end else if (scl_p && scl_n && !sda_p && sda_n) begin
                sb_check(K_STP, 0);
                act = 0; rdm = 0;
                slave_pull = 1'b0;
            end else if (act && !scl_p && scl_n) begin
                if (bitn < 8) sh = {sh[6:0], sda_n};
                else mack = sda_n;
                bitn++;
            end else if (act && scl_p && !scl_n) begin
                if (bitn == 8) begin
                    slave_pull = 1'b0;
                    if (!rdm) begin
                        sb_check(K_WR, sh);
                        slave_pull = !nack_wr;
                        if (first && sh[0]) rd_pend = 1;
                        first = 0;
                    end
                end else if (bitn == 9) begin
                    bitn = 0;
                    slave_pull = 1'b0;
                    if (rdm) begin
                        sb_check(K_ACK, mack);
                        if (mack) rdm = 0;
                        else rcur = (rdq.size() != 0) ? rdq.pop_front() : 8'hFF;
                    end else if (rd_pend && !nack_wr) begin
                        rdm = 1;
                        rcur = (rdq.size() != 0) ? rdq.pop_front() : 8'hFF;
                    end
                    rd_pend = 0;
                end
                if (rdm && bitn < 8) slave_pull = !rcur[7 - bitn];
            end
            if (bus.received && !rcv_p) sb_check(K_RD, bus.datareceive);
            if (bus.isReady && !rdy_p) begin
                sb_check(K_END, bus.ack_error);
                last_low = low_cnt;
                low_cnt = 0;
            end
            if (!bus.isReady) low_cnt++;
            if (bus.sended) snd_cnt++;
            if (!bus.sended && snd_p) begin
                last_snd = snd_cnt;
                snd_cnt = 0;
            end
            scl_p = scl_n; sda_p = sda_n;
            rdy_p = bus.isReady; rcv_p = bus.received; snd_p = bus.sended;
        end
    end

    initial begin
        int viol;
        n_cmp = 0; n_bad = 0; last_low = 0; last_snd = 0;
        sb_off = 1; nack_wr = 0;
        reset = 1'b0;
        bus.start = 0; bus.send = 0; bus.receive = 0; bus.datasend = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_isReady", bus.isReady, 1);
        chk("rst_sended", bus.sended, 0);
        chk("rst_received", bus.received, 0);
        chk("rst_datareceive", bus.datareceive, 0);
        chk("rst_ack_error", bus.ack_error, 0);
        chk("rst_scl_oe", bus.scl_oe, 0);
        chk("rst_sda_oe", bus.sda_oe, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        sb_off = 0;

        // Single write 0xEE with slave ACK
        expect_ev(K_STA, 0); expect_ev(K_WR, 'hEE);
        expect_ev(K_STP, 0); expect_ev(K_END, 0);
        bus.datasend = 8'hEE; bus.start = 1; bus.send = 1;
        wait_sended();
        bus.send = 0; bus.start = 0;
        wait_ready();
        chk("ready_low_clks", last_low, (2 + 36 + 4) * DIV);
        chk("sended_len_min", (last_snd >= 36 * DIV) ? 1 : 0, 1);

        // Requests that must not start a transaction
        viol = 0;
        bus.send = 1; bus.start = 0;
        repeat (200) begin
            @(negedge clk);
            if (!bus.isReady || bus.scl_oe || bus.sda_oe || bus.sended) viol++;
        end
        chk("idle_send_nostart", viol, 0);
        bus.send = 0;
        viol = 0;
        bus.receive = 1;
        repeat (200) begin
            @(negedge clk);
            if (!bus.isReady || bus.scl_oe || bus.sda_oe || bus.sended) viol++;
        end
        chk("idle_receive_only", viol, 0);
        bus.receive = 0;
        @(negedge clk);

        // BMP180 chip-id read: EE, D0, restart EF, read 0x55 with NACK
        rdq.push_back(8'h55);
        expect_ev(K_STA, 0); expect_ev(K_WR, 'hEE); expect_ev(K_WR, 'hD0);
        expect_ev(K_STA, 1); expect_ev(K_WR, 'hEF); expect_ev(K_RD, 'h55);
        expect_ev(K_ACK, 1); expect_ev(K_STP, 0); expect_ev(K_END, 0);
        bus.datasend = 8'hEE; bus.start = 1; bus.send = 1;
        wait_sended();
        bus.datasend = 8'hD0; bus.start = 0;
        wait_sended();
        bus.datasend = 8'hEF; bus.start = 1;
        wait_sended();
        bus.send = 0; bus.start = 0; bus.receive = 1;
        wait_lvl(1, 1'b1, "received_rise");
        bus.receive = 0;
        wait_ready();
        chk("bmp_datareceive", bus.datareceive, 'h55);
        chk("bmp_ack_error", bus.ack_error, 0);

        // Slave NACK: STOP even with receive requested
        nack_wr = 1;
        expect_ev(K_STA, 0); expect_ev(K_WR, 'hEE);
        expect_ev(K_STP, 0); expect_ev(K_END, 1);
        bus.datasend = 8'hEE; bus.start = 1; bus.send = 1;
        wait_sended();
        bus.send = 0; bus.start = 0; bus.receive = 1;
        wait_ready();
        bus.receive = 0;
        chk("nack_ack_error", bus.ack_error, 1);
        chk("nack_isReady", bus.isReady, 1);
        nack_wr = 0;

        // Next transaction clears ack_error
        expect_ev(K_STA, 0); expect_ev(K_WR, 'h90);
        expect_ev(K_STP, 0); expect_ev(K_END, 0);
        bus.datasend = 8'h90; bus.start = 1; bus.send = 1;
        wait_sended();
        chk("ack_error_cleared", bus.ack_error, 0);
        bus.send = 0; bus.start = 0;
        wait_ready();

        // Two-byte read: ACK after 0x12, NACK after 0x34
        rdq.push_back(8'h12); rdq.push_back(8'h34);
        expect_ev(K_STA, 0); expect_ev(K_WR, 'hEF);
        expect_ev(K_RD, 'h12); expect_ev(K_ACK, 0);
        expect_ev(K_RD, 'h34); expect_ev(K_ACK, 1);
        expect_ev(K_STP, 0); expect_ev(K_END, 0);
        bus.datasend = 8'hEF; bus.start = 1; bus.send = 1;
        wait_sended();
        bus.send = 0; bus.start = 0; bus.receive = 1;
        wait_lvl(1, 1'b1, "rx1_rise");
        wait_lvl(1, 1'b0, "rx1_fall");
        bus.receive = 0;
        wait_ready();
        chk("rd2_datareceive", bus.datareceive, 'h34);

        // Reset in the middle of TX bit 3
        expect_ev(K_STA, 0);
        bus.datasend = 8'hA5; bus.start = 1; bus.send = 1;
        wait_sended();
        bus.send = 0; bus.start = 0;
        repeat (4) @(negedge clk);
        sb_off = 1;
        repeat (74) @(negedge clk);
        chk("midtx_busy", bus.isReady, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_scl_oe", bus.scl_oe, 0);
        chk("midrst_sda_oe", bus.sda_oe, 0);
        chk("midrst_isReady", bus.isReady, 1);
        chk("midrst_sended", bus.sended, 0);
        chk("midrst_datareceive", bus.datareceive, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        sb_off = 0;

        repeat (20) @(negedge clk);
        while (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL sb_missing: got nothing, required %s=%0h",
                     kname(e.kind), e.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
